// File: rtl/aqp_sync_fifo_pkg.sv
// Shared helpers for the aqp sync FIFO slice: parameter sanity checks used at elaboration.
`timescale 1ns/1ps
package aqp_sync_fifo_pkg;

    // A threshold is usable only if it lies within 0..DEPTH.
    function automatic bit thresh_in_range(input int thresh, input int addr_w);
        return (thresh >= 0) && (thresh <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/aqp_fifo_dpram.sv
// WIDTH x 2**ADDR_W simple dual-port RAM: synchronous write, asynchronous read.
`timescale 1ns/1ps
module aqp_fifo_dpram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register lives in the FIFO, so the read port stays combinational.
    assign rdata = mem[raddr];

endmodule

// File: rtl/aqp_sync_fifo.sv
// Single-clock FIFO with full 2**ADDR_W capacity, optional first-word-fall-through,
// occupancy count, almost flags, synchronous flush and sticky error flags.
`timescale 1ns/1ps
module aqp_sync_fifo
    import aqp_sync_fifo_pkg::*;
#(
    parameter int WIDTH         = 9,
    parameter int ADDR_W        = 4,
    parameter int AFULL_THRESH  = 8,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [WIDTH-1:0]  wrdata,
    input  logic              wr_en,
    output logic [WIDTH-1:0]  rddata,
    input  logic              rd_en,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_THRESH);

    if (ADDR_W < 1) begin : g_bad_addr_w
        $error("aqp_sync_fifo: ADDR_W must be at least 1");
    end
    if (!thresh_in_range(AFULL_THRESH, ADDR_W)) begin : g_bad_afull
        $error("aqp_sync_fifo: AFULL_THRESH outside 0..DEPTH");
    end
    if (!thresh_in_range(AEMPTY_THRESH, ADDR_W)) begin : g_bad_aempty
        $error("aqp_sync_fifo: AEMPTY_THRESH outside 0..DEPTH");
    end

    logic [ADDR_W:0]  wptr_reg, rptr_reg;
    logic [ADDR_W:0]  wptr_next, rptr_next;
    logic [ADDR_W:0]  mcount;
    logic [ADDR_W:0]  count_int;
    logic             ovalid_reg, ovalid_next;
    logic             overflow_reg, underflow_reg;
    logic [WIDTH-1:0] rddata_reg;
    logic [WIDTH-1:0] mem_rdata;
    logic             full_int, mem_empty, empty_int;
    logic             wr_ok, wr_err, load, rd_err;

    // Extra wrap bit on each pointer lets all DEPTH slots be used.
    assign mcount    = wptr_reg - rptr_reg;
    assign full_int  = (mcount == DEPTH_CNT);
    assign mem_empty = (wptr_reg == rptr_reg);

    assign wr_ok  = wr_en && !full_int && !flush;
    assign wr_err = wr_en &&  full_int && !flush;

    if (FWFT) begin : g_fwft
        // Prefetch the head word whenever the output register is free or being popped.
        always_comb begin
            load        = !flush && (mcount != '0) && (!ovalid_reg || rd_en);
            rd_err      = rd_en && !ovalid_reg && !flush;
            ovalid_next = ovalid_reg;
            if (flush) begin
                ovalid_next = 1'b0;
            end else if (load) begin
                ovalid_next = 1'b1;
            end else if (rd_en && ovalid_reg) begin
                ovalid_next = 1'b0;
            end
            empty_int = !ovalid_reg;
        end
    end else begin : g_registered
        always_comb begin
            load        = rd_en && !mem_empty && !flush;
            rd_err      = rd_en &&  mem_empty && !flush;
            ovalid_next = 1'b0;
            empty_int   = mem_empty;
        end
    end

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_ok) begin
                wptr_next = wptr_reg + 1'b1;
            end
            if (load) begin
                rptr_next = rptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            ovalid_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rddata_reg    <= '0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            ovalid_reg    <= ovalid_next;
            // A fresh error in the same cycle as clr_err keeps the flag set.
            overflow_reg  <= wr_err || (overflow_reg  && !clr_err);
            underflow_reg <= rd_err || (underflow_reg && !clr_err);
            if (load) begin
                rddata_reg <= mem_rdata;
            end
        end
    end

    aqp_fifo_dpram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr_reg[ADDR_W-1:0]),
        .wdata (wrdata),
        .raddr (rptr_reg[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    // ovalid is constant 0 in registered-read mode, so one count formula serves both.
    assign count_int    = mcount + {{ADDR_W{1'b0}}, ovalid_reg};
    assign count        = count_int;
    assign empty        = empty_int;
    assign full         = full_int;
    assign almost_full  = (count_int >= AFULL_CNT);
    assign almost_empty = (count_int <= AEMPTY_CNT);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign rddata       = rddata_reg;

endmodule

// File: tb/tb_aqp_sync_fifo.sv
// Directed bench for aqp_sync_fifo: one registered-read and one FWFT instance, queue scoreboard.
`timescale 1ns/1ps
module tb_aqp_sync_fifo;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    // Registered-read instance
    logic       fl0 = 0, we0 = 0, re0 = 0, ce0 = 0;
    logic [8:0] wd0 = '0;
    logic [8:0] rd0;
    logic       e0, f0, af0, ae0, of0, uf0;
    logic [4:0] c0;

    // FWFT instance
    logic       fl1 = 0, we1 = 0, re1 = 0, ce1 = 0;
    logic [8:0] wd1 = '0;
    logic [8:0] rd1;
    logic       e1, f1, af1, ae1, of1, uf1;
    logic [4:0] c1;

    int vectors     = 0;
    int miscompares = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_w;
    logic [8:0] last0;
    logic [8:0] last1;

    always #5 clk = ~clk;

    aqp_sync_fifo #(.WIDTH(9), .ADDR_W(4), .AFULL_THRESH(8), .AEMPTY_THRESH(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(fl0), .wrdata(wd0), .wr_en(we0), .rddata(rd0),
        .rd_en(re0), .empty(e0), .full(f0), .almost_full(af0), .almost_empty(ae0),
        .count(c0), .overflow(of0), .underflow(uf0), .clr_err(ce0)
    );

    aqp_sync_fifo #(.WIDTH(9), .ADDR_W(4), .AFULL_THRESH(8), .AEMPTY_THRESH(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(fl1), .wrdata(wd1), .wr_en(we1), .rddata(rd1),
        .rd_en(re1), .empty(e1), .full(f1), .almost_full(af1), .almost_empty(ae1),
        .count(c1), .overflow(of1), .underflow(uf1), .clr_err(ce1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rddata0"}, 32'(rd0), 0);
        chk({tag, "_empty0"},  32'(e0),  1);
        chk({tag, "_full0"},   32'(f0),  0);
        chk({tag, "_aempty0"}, 32'(ae0), 1);
        chk({tag, "_afull0"},  32'(af0), 0);
        chk({tag, "_count0"},  32'(c0),  0);
        chk({tag, "_ovf0"},    32'(of0), 0);
        chk({tag, "_unf0"},    32'(uf0), 0);
        chk({tag, "_rddata1"}, 32'(rd1), 0);
        chk({tag, "_empty1"},  32'(e1),  1);
        chk({tag, "_count1"},  32'(c1),  0);
        chk({tag, "_full1"},   32'(f1),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        reset = 1'b1;
        repeat (2) tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        // Registered read: fill to 16, thresholds tracked on every step
        for (int i = 1; i <= 16; i++) begin
            wd0 = 9'h100 + 9'(i);
            we0 = 1'b1;
            q0.push_back(wd0);
            tick();
            $display("wr0 data=0x%03h count=%0d", wd0, c0);
            chk("fill_count",  32'(c0),  32'(i));
            chk("fill_afull",  32'(af0), 32'(i >= 8));
            chk("fill_aempty", 32'(ae0), 32'(i <= 2));
            chk("fill_empty",  32'(e0),  0);
        end
        chk("full_at_16", 32'(f0), 1);
        wd0 = 9'h1FF;
        tick();
        we0 = 1'b0;
        chk("ovf_set",        32'(of0), 1);
        chk("ovf_count_held", 32'(c0),  16);
        chk("ovf_full_held",  32'(f0),  1);

        // Drain in order, data one cycle after rd_en
        re0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_w = q0.pop_front();
            $display("rd0 data=0x%03h count=%0d", rd0, c0);
            chk("drain_data",  32'(rd0), 32'(exp_w));
            chk("drain_count", 32'(c0),  32'(15 - i));
        end
        re0 = 1'b0;
        chk("drain_empty", 32'(e0), 1);

        // Underflow and clear
        re0 = 1'b1;
        tick();
        re0 = 1'b0;
        chk("unf_set",    32'(uf0), 1);
        chk("unf_rddata", 32'(rd0), 32'h110);
        ce0 = 1'b1;
        tick();
        ce0 = 1'b0;
        chk("clr_unf", 32'(uf0), 0);
        chk("clr_ovf", 32'(of0), 0);

        // Simultaneous read+write at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            wd0 = 9'h020 + 9'(i);
            we0 = 1'b1;
            q0.push_back(wd0);
            tick();
        end
        re0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wd0 = 9'h040 + 9'(i);
            q0.push_back(wd0);
            tick();
            exp_w = q0.pop_front();
            $display("rw0 wr=0x%03h rd=0x%03h count=%0d", wd0, rd0, c0);
            chk("rw_data",  32'(rd0), 32'(exp_w));
            chk("rw_count", 32'(c0),  5);
        end
        we0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_w = q0.pop_front();
            chk("rw_drain", 32'(rd0), 32'(exp_w));
        end
        re0   = 1'b0;
        last0 = exp_w;
        chk("rw_empty", 32'(e0), 1);

        // Flush at count 9 with simultaneous wr/rd ignored
        for (int i = 0; i < 9; i++) begin
            wd0 = 9'h060 + 9'(i);
            we0 = 1'b1;
            tick();
        end
        we0 = 1'b0;
        chk("pre_flush_count", 32'(c0), 9);
        fl0 = 1'b1; we0 = 1'b1; re0 = 1'b1; wd0 = 9'h0FF;
        tick();
        fl0 = 1'b0; we0 = 1'b0; re0 = 1'b0;
        chk("flush_count",  32'(c0),  0);
        chk("flush_empty",  32'(e0),  1);
        chk("flush_rddata", 32'(rd0), 32'(last0));
        chk("flush_ovf",    32'(of0), 0);
        chk("flush_unf",    32'(uf0), 0);

        // FWFT: single word falls through two edges after the write
        wd1 = 9'h0AA;
        we1 = 1'b1;
        tick();
        we1 = 1'b0;
        chk("fwft_empty_wr_edge", 32'(e1), 1);
        chk("fwft_count_wr_edge", 32'(c1), 1);
        tick();
        chk("fwft_empty_load", 32'(e1),  0);
        chk("fwft_head",       32'(rd1), 32'h0AA);
        chk("fwft_count_load", 32'(c1),  1);
        tick();
        chk("fwft_head_hold", 32'(rd1), 32'h0AA);
        re1 = 1'b1;
        tick();
        re1 = 1'b0;
        chk("fwft_pop_empty", 32'(e1), 1);
        chk("fwft_pop_count", 32'(c1), 0);

        // FWFT: capacity is DEPTH in memory plus the output register
        for (int i = 0; i < 17; i++) begin
            wd1 = 9'h0C0 + 9'(i);
            we1 = 1'b1;
            q1.push_back(wd1);
            tick();
        end
        wd1 = 9'h1EE;
        tick();
        we1 = 1'b0;
        chk("fwft_count17", 32'(c1),  17);
        chk("fwft_full",    32'(f1),  1);
        chk("fwft_ovf",     32'(of1), 1);
        chk("fwft_afull",   32'(af1), 1);
        chk("fwft_aempty",  32'(ae1), 0);
        for (int i = 0; i < 17; i++) begin
            exp_w = q1.pop_front();
            $display("rd1 data=0x%03h count=%0d", rd1, c1);
            chk("fwft_drain_valid", 32'(e1),  0);
            chk("fwft_drain_data",  32'(rd1), 32'(exp_w));
            re1 = 1'b1;
            tick();
        end
        re1   = 1'b0;
        last1 = exp_w;
        chk("fwft_drain_empty", 32'(e1), 1);
        chk("fwft_drain_count", 32'(c1), 0);

        // FWFT underflow; error in the same cycle as clr_err wins
        re1 = 1'b1;
        tick();
        re1 = 1'b0;
        chk("fwft_unf",        32'(uf1), 1);
        chk("fwft_unf_rddata", 32'(rd1), 32'(last1));
        ce1 = 1'b1;
        re1 = 1'b1;
        tick();
        re1 = 1'b0;
        chk("fwft_clr_vs_err", 32'(uf1), 1);
        tick();
        ce1 = 1'b0;
        chk("fwft_clr_unf", 32'(uf1), 0);
        chk("fwft_clr_ovf", 32'(of1), 0);

        // Reset mid-write at count 7 clears everything immediately
        for (int i = 0; i < 3; i++) begin
            wd1 = 9'h0E0 + 9'(i);
            we1 = 1'b1;
            tick();
        end
        we1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wd0 = 9'h070 + 9'(i);
            we0 = 1'b1;
            tick();
        end
        chk("pre_reset_count", 32'(c0), 7);
        wd0 = 9'h077;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        tick();
        reset = 1'b0;
        we0   = 1'b0;
        tick();

        // Post-reset write/read
        q0.delete();
        for (int i = 0; i < 2; i++) begin
            wd0 = 9'h0A1 + 9'(i);
            we0 = 1'b1;
            q0.push_back(wd0);
            tick();
        end
        we0 = 1'b0;
        chk("post_reset_count", 32'(c0), 2);
        re0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_w = q0.pop_front();
            chk("post_reset_data", 32'(rd0), 32'(exp_w));
        end
        re0 = 1'b0;
        chk("post_reset_empty", 32'(e0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
